capture_sequencer: RTL and testbench
====================================

# capture_sequencer

Sequences audio capture into the sample BRAM and exposes it to software over Avalon-MM. The block sits between the audio driver's sample strobe and the single-write/single-read BRAM. It arms on software command, waits for a magnitude trigger, then writes a programmable number of 24-bit samples. It serves sample readout through a register window with an auto-incrementing read pointer.

## Interface
Parameters:
- DEPTH, 48000: BRAM words available; maximum capture length.
- ADDR_BITS, 16: BRAM address width.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- sample_valid  in  1  one-cycle strobe, new sample on sample_data.
- sample_data  in  24  signed two's-complement mono sample.
- chipselect  in  1  Avalon select.
- read  in  1  Avalon read; fixed read latency 1.
- write  in  1  Avalon write.
- address  in  3  register index.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, registered.
- bram_wa  out  ADDR_BITS  BRAM write address.
- bram_write  out  1  BRAM write enable.
- bram_data_in  out  24  BRAM write data.
- bram_ra  out  ADDR_BITS  BRAM read address; equals rptr.
- bram_data_out  in  24  BRAM read data; valid 1 cycle after bram_ra changes.
- done_irq  out  1  high while state is DONE.

## Operation
Register map (address):
- 0 CTRL, write-only; reads return 0. bit0 ARM, bit1 ABORT, bit2 REWIND (rptr←0).
- 1 STATUS, read-only. [1:0] state, [31:16] wcount.
- 2 THRESH, R/W, [23:0] unsigned trigger level. Reset value 0, which means immediate trigger.
- 3 DATA, read-only. Returns sign-extended bram_data_out, then rptr advances.
- 4 RPTR, R/W, [ADDR_BITS-1:0].
- 5 COUNT, R/W, capture length. Reset value DEPTH.
  - Writes are accepted only in IDLE or DONE.
  - A written value of 0 is stored as 1; a value above DEPTH is stored as DEPTH.
- 6, 7: reads return 0; writes are ignored.

State machine (encoding IDLE=0, ARMED=1, CAPTURE=2, DONE=3):
- IDLE: ARM → ARMED, wcount←0.
- ARMED: a sample_valid with mag(sample_data) ≥ THRESH writes that sample at address 0 and sets wcount←1.
  - The next state is CAPTURE, or DONE if COUNT=1.
- CAPTURE: each sample_valid writes at address wcount and sets wcount←wcount+1. The write that makes wcount=COUNT transitions to DONE.
- DONE: holds. ARM restarts: ARMED, wcount←0.
- ABORT in any state → IDLE; wcount is retained.
- ARM in ARMED or CAPTURE restarts: ARMED, wcount←0.
- ARM and ABORT in the same write: ABORT wins.
- A CTRL write and sample_valid in the same cycle: the CTRL action wins and the sample is not written.

Arithmetic:
- mag(x) = |x| as an unsigned 24-bit value; mag(−2^23) saturates to 2^23−1.
- rptr wraps to 0 after COUNT−1.
- A RPTR write of a value ≥ COUNT stores 0.
- REWIND and a DATA read in the same cycle cannot occur, because writes and reads are exclusive per Avalon cycle.

## Timing
- Reset values:
  - Outputs: readdata=0, bram_write=0, bram_wa=0, bram_data_in=0, bram_ra=0, done_irq=0.
  - State and registers: state=IDLE, wcount=0, rptr=0, THRESH=0, COUNT=DEPTH.
- Write path: sample_valid accepted at cycle t → bram_write=1 for exactly cycle t+1, with bram_wa/bram_data_in registered. wcount and state update at t+1.
- Read path, DATA read at t:
  - readdata at t+1 = sext(bram_data_out sampled at t).
  - rptr/bram_ra update at t+1.
  - New data is valid at t+2.
  - DATA reads must be ≥2 cycles apart; the HPS bridge guarantees this.
- Other register reads: readdata at t+1. readdata holds its value between reads.
- done_irq rises in the same cycle the state becomes DONE and falls the cycle after ARM/ABORT is accepted.
- Reset mid-CAPTURE: IDLE in the next cycle; no further bram_write.
- Reads are permitted in any state. Reading during CAPTURE returns whatever BRAM holds.

## Test plan
- Capture with immediate trigger:
  - Stimulus: COUNT=4, THRESH=0, ARM, then sample_valid with 0x000010, 0xFFFFF0, 0x7FFFFF, 0x800000.
  - Required: 4 bram_write pulses at addresses 0..3, state DONE, done_irq=1, STATUS[31:16]=4.
  - Readout: REWIND, then 5 DATA reads return 0x00000010, 0xFFFFFFF0, 0x007FFFFF, 0xFF800000, 0x00000010 (wrap).
- Trigger:
  - Stimulus: THRESH=0x100, ARM, then samples 0x0000FF, 0xFFFF01, 0xFFFF00.
  - Required: the first two are ignored; 0xFFFF00 (mag 0x100) is written at address 0 and the state is CAPTURE.
- Abort and precedence:
  - Abort mid-capture: after 2 of COUNT=8 samples, ABORT → IDLE, wcount=2, no further writes.
  - Same-cycle CTRL/sample: CTRL write ARM|ABORT coincident with sample_valid → IDLE, no bram_write.
- COUNT clamping: a COUNT write of 0 reads back 1; DEPTH+5 reads back DEPTH; a write during CAPTURE is ignored.
- Reset: assert reset during CAPTURE → all outputs 0 next cycle, STATUS=0, COUNT=DEPTH.

Source files
------------

// File: rtl/capture_sequencer.sv
// capture_sequencer: arms on command, triggers on sample magnitude, captures
// into the sample BRAM and serves readout over an Avalon-MM register window.
module capture_sequencer #(
    parameter int DEPTH     = 48000,
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_valid,
    input  logic [23:0]          sample_data,
    input  logic                 chipselect,
    input  logic                 read,
    input  logic                 write,
    input  logic [2:0]           address,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    output logic [ADDR_BITS-1:0] bram_wa,
    output logic                 bram_write,
    output logic [23:0]          bram_data_in,
    output logic [ADDR_BITS-1:0] bram_ra,
    input  logic [23:0]          bram_data_out,
    output logic                 done_irq
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;
    state_t state, state_d;
    logic [ADDR_BITS-1:0] wcount, rptr, count, rptr_inc, rptr_wr;
    logic [23:0] thresh, mag;
    logic [31:0] rd_mux;
    logic ctrl_wr, arm, abort, accept, rd, reg_wr;

    assign reg_wr   = chipselect && write;
    assign rd       = chipselect && read;
    assign ctrl_wr  = reg_wr && address == 3'd0;
    assign abort    = ctrl_wr && writedata[1];
    assign arm      = ctrl_wr && writedata[0] && !writedata[1];
    // -2^23 has no positive twin in 24 bits, so it saturates
    assign mag      = !sample_data[23] ? sample_data :
                      sample_data == 24'h800000 ? 24'h7FFFFF : -sample_data;
    assign accept   = sample_valid && !ctrl_wr &&
                      (state == CAPTURE || (state == ARMED && mag >= thresh));
    assign rptr_inc = 32'(rptr) + 32'd1 >= 32'(count) ? '0 : rptr + 1'b1;
    assign rptr_wr  = writedata[ADDR_BITS-1:0] >= count ? '0 : writedata[ADDR_BITS-1:0];
    assign done_irq = state == DONE;
    assign bram_ra  = rptr;

    always_comb begin
        state_d = abort ? IDLE : arm ? ARMED :
                  accept ? (wcount + 1'b1 >= count ? DONE : CAPTURE) : state;
    end

    always_comb begin
        rd_mux = 32'd0;
        case (address)
            3'd1: rd_mux = {16'(wcount), 14'd0, state};
            3'd2: rd_mux = {8'd0, thresh};
            3'd3: rd_mux = {{8{bram_data_out[23]}}, bram_data_out};
            3'd4: rd_mux = 32'(rptr);
            3'd5: rd_mux = 32'(count);
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcount       <= '0;
            rptr         <= '0;
            thresh       <= '0;
            count        <= ADDR_BITS'(DEPTH);
            readdata     <= '0;
            bram_write   <= 1'b0;
            bram_wa      <= '0;
            bram_data_in <= '0;
        end else begin
            bram_write <= accept;
            if (arm)
                wcount <= '0;
            else if (accept)
                wcount <= wcount + 1'b1;
            if (accept) begin
                bram_wa      <= wcount;
                bram_data_in <= sample_data;
            end
            if (rd)
                readdata <= rd_mux;
            if (ctrl_wr && writedata[2])
                rptr <= '0;
            else if (reg_wr && address == 3'd4)
                rptr <= rptr_wr;
            else if (rd && address == 3'd3)
                rptr <= rptr_inc;
            if (reg_wr && address == 3'd2)
                thresh <= writedata[23:0];
            // length is frozen while a capture is in flight
            if (reg_wr && address == 3'd5 && (state == IDLE || state == DONE))
                count <= writedata == 32'd0 ? ADDR_BITS'(1) :
                         writedata > 32'(DEPTH) ? ADDR_BITS'(DEPTH) : writedata[ADDR_BITS-1:0];
        end
    end
endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: directed plus random stimulus against a behavioural
// model; expected BRAM writes and register reads are queued and checked by a monitor.
module tb_capture_sequencer;
    localparam int DEPTH = 48000;
    localparam int AB = 16;
    localparam int M_IDLE = 0, M_ARMED = 1, M_CAPTURE = 2, M_DONE = 3;

    logic clk = 1'b0, reset = 1'b1, sample_valid = 1'b0, chipselect = 1'b0, read = 1'b0, write = 1'b0;
    logic [23:0] sample_data = '0;
    logic [2:0] address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [AB-1:0] bram_wa, bram_ra;
    logic bram_write, done_irq;
    logic [23:0] bram_data_in;
    logic [23:0] bram_data_out = '0;

    logic [23:0] bmem [0:65535];
    logic [23:0] m_mem [0:65535];
    int m_state = M_IDLE, m_wcount = 0, m_rptr = 0, m_thresh = 0, m_count = DEPTH;
    logic [39:0] wq [$];
    logic [31:0] rq [$];
    int checks = 0, failures = 0, quiet = 0;

    capture_sequencer #(.DEPTH(DEPTH), .ADDR_BITS(AB)) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data),
        .chipselect(chipselect), .read(read), .write(write), .address(address),
        .writedata(writedata), .readdata(readdata), .bram_wa(bram_wa), .bram_write(bram_write),
        .bram_data_in(bram_data_in), .bram_ra(bram_ra), .bram_data_out(bram_data_out),
        .done_irq(done_irq)
    );

    always #5 clk = ~clk;

    // single-port-read BRAM with one cycle of read latency, read-before-write
    always @(posedge clk) begin
        bram_data_out <= bmem[bram_ra];
        if (bram_write) bmem[bram_wa] = bram_data_in;
    end

    task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // reference model: applies one cycle of bench inputs to the register-level state
    task automatic model_step();
        int m;
        logic [31:0] e;
        bit ctrl, ev;
        ev = 0;
        if (reset) begin
            m_state = M_IDLE; m_wcount = 0; m_rptr = 0; m_thresh = 0; m_count = DEPTH;
            quiet = 0;
            return;
        end
        ctrl = chipselect && write && address == 3'd0;
        if (chipselect && read) begin
            case (address)
                3'd1: e = (32'(m_wcount) << 16) | 32'(m_state);
                3'd2: e = 32'(m_thresh);
                3'd3: e = 32'($signed(m_mem[m_rptr]));
                3'd4: e = 32'(m_rptr);
                3'd5: e = 32'(m_count);
                default: e = 32'd0;
            endcase
            rq.push_back(e);
            if (address == 3'd3) begin
                m_rptr = (m_rptr + 1 >= m_count) ? 0 : m_rptr + 1;
                ev = 1;
            end
        end
        if (chipselect && write) begin
            case (address)
                3'd0: begin
                    if (writedata[1]) m_state = M_IDLE;
                    else if (writedata[0]) begin m_state = M_ARMED; m_wcount = 0; end
                    if (writedata[2]) m_rptr = 0;
                    ev = 1;
                end
                3'd2: m_thresh = int'(writedata[23:0]);
                3'd4: begin m_rptr = (int'(writedata[15:0]) >= m_count) ? 0 : int'(writedata[15:0]); ev = 1; end
                3'd5: if (m_state == M_IDLE || m_state == M_DONE)
                    m_count = (writedata == 0) ? 1 : (writedata > DEPTH) ? DEPTH : int'(writedata);
                default: ;
            endcase
        end
        if (sample_valid && !ctrl) begin
            m = int'($signed(sample_data));
            m = m < 0 ? -m : m;
            if (m > 'h7FFFFF) m = 'h7FFFFF;
            if (m_state == M_CAPTURE || (m_state == M_ARMED && m >= m_thresh)) begin
                m_mem[m_wcount] = sample_data;
                wq.push_back({16'(m_wcount), sample_data});
                m_wcount++;
                m_state = (m_wcount == m_count) ? M_DONE : M_CAPTURE;
                ev = 1;
            end
        end
        quiet = ev ? 0 : quiet + 1;
    endtask

    always @(negedge clk) begin
        logic [39:0] ew;
        logic [31:0] er;
        if (bram_write) begin
            if (wq.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_write: got wa=%0h data=%0h expected no write", bram_wa, bram_data_in);
            end else begin
                ew = wq.pop_front();
                check("bram_write", {bram_wa, bram_data_in}, ew);
            end
        end else if (wq.size() != 0) begin
            ew = wq.pop_front();
            checks++; failures++;
            $display("FAIL missing_write: got no write expected wa=%0h data=%0h", ew[39:24], ew[23:0]);
        end
        if (rq.size() != 0) begin
            er = rq.pop_front();
            check("readdata", readdata, er);
        end
        check("done_irq", 64'(done_irq), 64'(m_state == M_DONE));
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        sample_valid = 0; chipselect = 0; read = 0; write = 0;
    endtask
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1; write = 1; address = a; writedata = d; tick();
    endtask
    task automatic rd(input logic [2:0] a);
        chipselect = 1; read = 1; address = a; tick();
    endtask
    task automatic smp(input logic [23:0] d);
        sample_valid = 1; sample_data = d; tick();
    endtask
    task automatic idle(input int n);
        repeat (n) tick();
    endtask
    task automatic check_outputs_zero(input string n);
        check({n, "_readdata"}, 64'(readdata), 64'd0);
        check({n, "_bram_wa"}, 64'(bram_wa), 64'd0);
        check({n, "_bram_write"}, 64'(bram_write), 64'd0);
        check({n, "_bram_data_in"}, 64'(bram_data_in), 64'd0);
        check({n, "_bram_ra"}, 64'(bram_ra), 64'd0);
        check({n, "_done_irq"}, 64'(done_irq), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin bmem[i] = '0; m_mem[i] = '0; end
        idle(2);
        check_outputs_zero("reset");
        reset = 0;
        rd(1); rd(5); rd(2); rd(4);

        // immediate trigger capture of 4 and wrapped readout
        wr(5, 4); wr(2, 0); wr(0, 1);
        smp(24'h000010); smp(24'hFFFFF0); smp(24'h7FFFFF); smp(24'h800000);
        idle(3); rd(1);
        wr(0, 4); idle(2);
        repeat (5) begin rd(3); idle(1); end

        // magnitude trigger
        wr(2, 'h100); wr(0, 1);
        smp(24'h0000FF); smp(24'hFFFF01); smp(24'hFFFF00);
        idle(1); rd(1);

        // abort mid-capture, then CTRL and sample in the same cycle
        wr(0, 2); wr(5, 8); wr(2, 0); wr(0, 1);
        smp(24'h000001); smp(24'h000002);
        wr(0, 2);
        smp(24'h000003); smp(24'h000004);
        rd(1);
        wr(0, 1);
        sample_valid = 1; sample_data = 24'h000005;
        wr(0, 3);
        idle(1); rd(1);

        // COUNT clamping and freeze during capture
        wr(5, 0); rd(5);
        wr(5, DEPTH + 5); rd(5);
        wr(0, 1); smp(24'h000007);
        wr(5, 5); rd(5); rd(1);

        // reset during capture, with a sample offered on the reset cycle
        smp(24'h000008); idle(1);
        reset = 1; sample_valid = 1; sample_data = 24'h000009;
        tick();
        check_outputs_zero("midreset");
        reset = 0;
        rd(1); rd(5); rd(2); rd(4);

        // randomized traffic
        wr(5, 6); wr(0, 1);
        for (int i = 0; i < 3000; i++) begin
            int r, a;
            r = $urandom_range(99);
            sample_valid = $urandom_range(2) == 0;
            case ($urandom_range(5))
                0: sample_data = 24'h800000;
                1: sample_data = 24'h7FFFFF;
                2: sample_data = 24'($urandom_range(300));
                default: sample_data = 24'($urandom);
            endcase
            if (r < 3) begin
                chipselect = 1; write = 1; address = 0; writedata = 32'($urandom_range(7));
            end else if (r < 6) begin
                chipselect = 1; write = 1; address = 5;
                writedata = ($urandom_range(15) == 0) ? 32'($urandom_range(1)) * (DEPTH + 5)
                                                      : 32'($urandom_range(1, 12));
            end else if (r < 9) begin
                chipselect = 1; write = 1; address = 2;
                writedata = ($urandom_range(3) == 0) ? 32'($urandom_range(24'h800000, 24'h7FFFF0))
                                                     : 32'($urandom_range(400));
            end else if (r < 10) begin
                chipselect = 1; write = 1; address = 4; writedata = 32'($urandom_range(15));
            end else if (r < 20) begin
                a = $urandom_range(7);
                if (a == 3 && quiet < 3) a = 1;
                chipselect = 1; read = 1; address = 3'(a);
            end
            tick();
        end
        idle(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
